// File: rtl/timer_display_decoder.sv
// timer_display_decoder
// Turns the countdown timer's binary seconds and run state into four mm:ss BCD
// digits plus colon/blank attributes for the VGA character renderer. A
// conversion starts on each frame_start pulse. The FSM is idle when it starts.
// The conversion uses repeated subtraction, one step per cycle. All outputs
// update together in a single commit cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   time_in      remaining seconds, unsigned (clamped to MAX_SECONDS)
//   state_in     00 counting, 01 stopped, 10 (as 01), 11 finished
//   frame_start  one-cycle pulse at start of vertical blank
//   min_tens, min_units, sec_tens, sec_units   BCD digits
//   colon_on     draw the colon glyph
//   blank_digits suppress all digit glyphs
//   digits_valid one-cycle pulse when new outputs commit
//   busy         conversion in progress
//
// Build option: define TIMER_DISPLAY_BLINK_EN to enable the frame counter and
// the blinking colon/digit attributes. When it is undefined, the colon is always
// on and the digits are never blanked.

module timer_display_decoder #(
  parameter int unsigned MAX_SECONDS       = 5999,
  parameter int unsigned BLINK_FRAMES_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] time_in,
  input  logic [1:0]  state_in,
  input  logic        frame_start,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_units,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_units,
  output logic        colon_on,
  output logic        blank_digits,
  output logic        digits_valid,
  output logic        busy
);

  localparam int unsigned REM_W  = 13;
  localparam int unsigned MINQ_W = 7;
  localparam int unsigned CNT_W  = BLINK_FRAMES_LOG2 + 1;

  localparam logic [REM_W-1:0]  REM_SIXTY = REM_W'(60);
  localparam logic [REM_W-1:0]  REM_TEN   = REM_W'(10);
  localparam logic [MINQ_W-1:0] MINQ_TEN  = MINQ_W'(10);
  localparam logic [15:0]       MAX_TIME  = 16'(MAX_SECONDS);

  // Capture happens on the IDLE exit edge itself, so MIN is the first working state.
  typedef enum logic [2:0] {
    S_IDLE,
    S_MIN,
    S_SECT,
    S_MINT,
    S_COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [REM_W-1:0]  rem_q;
  logic [MINQ_W-1:0] minq_q;
  logic [3:0]        sect_q;
  logic [3:0]        mint_q;
  logic [1:0]        st_q;
  logic              start_c;
  logic              finished_c;
  logic [REM_W-1:0]  clamped_c;

  assign start_c    = (state_q == S_IDLE) && frame_start && !busy;
  assign finished_c = (st_q == 2'b11);
  assign clamped_c  = (time_in > MAX_TIME) ? REM_W'(MAX_SECONDS) : REM_W'(time_in);

`ifdef TIMER_DISPLAY_BLINK_EN
  logic [CNT_W-1:0] frame_cnt_q;
  logic             phase_q;

  // Frame counter advances on every frame, busy or not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_start) begin
      frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end
`else
  assign colon_on     = 1'b1;
  assign blank_digits = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each phase stays put while a subtraction is still due.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_c) state_d = S_MIN;
      S_MIN:    if (rem_q < REM_SIXTY) state_d = S_SECT;
      S_SECT:   if (rem_q < REM_TEN) state_d = S_MINT;
      S_MINT:   if (minq_q < MINQ_TEN) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q        <= '0;
      minq_q       <= '0;
      sect_q       <= '0;
      mint_q       <= '0;
      st_q         <= '0;
      min_tens     <= '0;
      min_units    <= '0;
      sec_tens     <= '0;
      sec_units    <= '0;
      digits_valid <= 1'b0;
      busy         <= 1'b0;
`ifdef TIMER_DISPLAY_BLINK_EN
      phase_q      <= 1'b0;
      colon_on     <= 1'b1;
      blank_digits <= 1'b0;
`endif
    end else begin
      digits_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            rem_q  <= clamped_c;
            minq_q <= '0;
            sect_q <= '0;
            mint_q <= '0;
            st_q   <= state_in;
            busy   <= 1'b1;
`ifdef TIMER_DISPLAY_BLINK_EN
            phase_q <= frame_cnt_q[BLINK_FRAMES_LOG2];
`endif
          end
        end
        S_MIN: begin
          if (rem_q >= REM_SIXTY) begin
            rem_q  <= rem_q - REM_SIXTY;
            minq_q <= minq_q + MINQ_W'(1);
          end
        end
        S_SECT: begin
          if (rem_q >= REM_TEN) begin
            rem_q  <= rem_q - REM_TEN;
            sect_q <= sect_q + 4'd1;
          end
        end
        S_MINT: begin
          if (minq_q >= MINQ_TEN) begin
            minq_q <= minq_q - MINQ_TEN;
            mint_q <= mint_q + 4'd1;
          end
        end
        S_COMMIT: begin
          // Finished state always reads 00:00 whatever the captured time was.
          min_tens     <= finished_c ? 4'd0 : mint_q;
          min_units    <= finished_c ? 4'd0 : minq_q[3:0];
          sec_tens     <= finished_c ? 4'd0 : sect_q;
          sec_units    <= finished_c ? 4'd0 : rem_q[3:0];
          digits_valid <= 1'b1;
          busy         <= 1'b0;
`ifdef TIMER_DISPLAY_BLINK_EN
          case (st_q)
            2'b00: begin
              colon_on     <= ~phase_q;
              blank_digits <= 1'b0;
            end
            2'b11: begin
              colon_on     <= phase_q;
              blank_digits <= phase_q;
            end
            default: begin
              colon_on     <= 1'b1;
              blank_digits <= phase_q;
            end
          endcase
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/timer_display_decoder.md
# timer_display_decoder

Converts the countdown timer's binary seconds value and run state into four mm:ss digit codes and blink attributes for the VGA character renderer. Sits between the timer controller's `_time`/`state` outputs and the glyph lookup stage. Conversion runs once per video frame, started by the VGA timing generator's frame pulse, and commits all outputs atomically so the renderer never draws a half-updated value.

## Interface
- `MAX_SECONDS`, default 5999: clamp ceiling, which displays as 99:59.
- `BLINK_FRAMES_LOG2`, default 5: the blink phase toggles every 2^N frames (32 frames ≈ 0.53 s at 60 Hz).

Ports:
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `time_in` in 16: remaining time, unsigned binary seconds.
- `state_in` in 2: timer state; 00 counting, 01 stopped, 10 unused, 11 finished.
- `frame_start` in 1: one-cycle pulse at the start of vertical blank.
- `min_tens`, `min_units`, `sec_tens`, `sec_units` out 4 each: BCD digits, each 0–9.
- `colon_on` out 1: draw the colon glyph.
- `blank_digits` out 1: suppress all four digit glyphs.
- `digits_valid` out 1: one-cycle pulse when a new set of outputs commits.
- `busy` out 1: conversion in progress.

## Operation
- **Reset values:** all digits 0, `colon_on`=1, `blank_digits`=0, `digits_valid`=0, `busy`=0, frame counter 0, blink phase 0, FSM in IDLE.
- **Frame counter:** advances on every `frame_start`, including frames that arrive while `busy`. Blink phase is counter bit [BLINK_FRAMES_LOG2].
- **FSM IDLE → CAPTURE:** leaves IDLE on `frame_start` while not busy.
  - Latches `time_in` clamped to MAX_SECONDS.
  - Latches `state_in` and the blink phase.
  - Sets `busy`.
- **MIN:** while remainder ≥ 60, subtract 60 and increment the minutes quotient (one subtraction per cycle). When remainder < 60, go to SECT.
- **SECT:** while seconds ≥ 10, subtract 10 and increment `sec_tens`. Then go to MINT.
- **MINT:** same as SECT, applied to minutes. Then go to COMMIT.
- **COMMIT:** update all outputs in one cycle, pulse `digits_valid`, clear `busy`, return to IDLE.
- **Attributes applied at COMMIT** (using the latched state and phase):
  - 00 counting: digits shown; `colon_on` = ~phase.
  - 01 stopped: `blank_digits` = phase; `colon_on` = 1.
  - 11 finished: digits forced to 00:00 regardless of `time_in`; `blank_digits` = phase; `colon_on` = phase.
  - 10: treated as 01.
- **Internal widths:** minutes quotient 7 bits, remainder 13 bits. The clamp guarantees no overflow.

## Timing
- Edge 0 is the edge that samples `frame_start`=1 in IDLE.
- Latency L = q_min + q_sect + q_mint + 4 edges, where each q is the number of subtractions in that phase. `digits_valid` is high in the cycle after edge L.
- L ranges from 4 (value 0) to 117 (5999). This always completes inside vertical blank.
- `frame_start` while `busy`: no restart. It only advances the frame counter.
- Outputs hold their values between commits. `time_in`/`state_in` changes during conversion are ignored.
- **Reset mid-conversion:** on the next edge, the FSM returns to IDLE and all outputs take their reset values. No `digits_valid` pulse is produced.
- `frame_start` during reset: ignored.

## Configuration
- Macro: `TIMER_DISPLAY_BLINK_EN`.
- **Defined:** blink behaviour exactly as described in Operation.
- **Undefined:**
  - Frame counter is removed.
  - `colon_on` is constant 1 and `blank_digits` is constant 0.
  - Finished-state forcing to 00:00 is still applied.
  - Digit conversion and latency are unchanged.

## Test plan
- Reset, then `time_in`=125, state 00, one `frame_start`:
  - digits 0,2,0,5.
  - `digits_valid` high in the cycle after edge 6.
  - `colon_on`=1 (phase 0).
- `time_in`=0xFFFF, state 00:
  - clamps to 99:59.
  - `digits_valid` after edge 117.
  - a `frame_start` at edge 50 does not restart the conversion; the frame counter shows 2.
- `time_in`=600, state 01; after 32 frames `blank_digits`=1, at frame 64 `blank_digits`=0. Digits 1,0,0,0 throughout.
- `time_in`=37, state 11: digits forced to 0,0,0,0; `colon_on` and `blank_digits` follow the phase.
- `rst_n` low at edge 10 of a 5999 conversion:
  - the next edge gives reset values.
  - no `digits_valid` pulse appears.
  - the next `frame_start` converts normally.
- Build without `TIMER_DISPLAY_BLINK_EN`, state 01 for 64 frames: `blank_digits` stays 0 and `colon_on` stays 1.
